// File: rtl/smc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smc_pkg
//  Description : Shared constants and types for the sequential Super MOSFET
//                Calculator core (operand/result widths, mode bit positions,
//                FSM state encoding, result weights and divisors).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package smc_pkg;

    localparam int N_TR         = 6;   // transistors per transaction
    localparam int VW           = 3;   // width of W, V_GS, V_DS
    localparam int OW           = 10;  // width of out_n
    localparam int VALW         = 7;   // per-transistor value width (max 84)
    localparam int PW           = 10;  // product width, holds up to 7*36=252
    localparam int SUMW         = 11;  // weighted-sum width, holds up to 12*84
    localparam int IDXW         = 3;   // transistor index width

    localparam int MODE_ID_BIT  = 0;   // 1 = I_D, 0 = gm
    localparam int MODE_MAX_BIT = 1;   // 1 = largest three, 0 = smallest three

    localparam int WGT_N0       = 3;
    localparam int WGT_N1       = 4;
    localparam int WGT_N2       = 5;
    localparam int DIV_EVAL     = 3;   // per-transistor divisor
    localparam int DIV_ID       = 12;  // I_D result divisor (3+4+5)
    localparam int DIV_GM       = 3;   // gm result divisor

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } smc_state_t;

endpackage
`default_nettype wire

// File: rtl/smc_eval_unit.sv
`default_nettype none
// ============================================================================
//  Module      : smc_eval_unit
//  Description : Combinational single-transistor evaluator. Produces either
//                floor(I_D) or floor(gm) for one (W, V_GS, V_DS) triplet,
//                using overdrive ov = V_GS-1 clamped at zero.
//  Ports       : w, vgs, vds - unsigned operands (VW bits)
//                sel_id      - 1 selects I_D, 0 selects gm
//                value       - result (VALW bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module smc_eval_unit
    import smc_pkg::*;
(
    input  logic [VW-1:0]   w,
    input  logic [VW-1:0]   vgs,
    input  logic [VW-1:0]   vds,
    input  logic            sel_id,
    output logic [VALW-1:0] value
);

    logic [VW-1:0] w_ov;
    logic          w_triode;
    logic [PW-1:0] w_w;
    logic [PW-1:0] w_o;
    logic [PW-1:0] w_d;
    logic [PW-1:0] w_id_num;
    logic [PW-1:0] w_gm_num;

    assign w_ov     = (vgs == '0) ? '0 : vgs - VW'(1);
    assign w_triode = (w_ov > vds);

    // Widen before multiplying so no partial product is truncated.
    assign w_w = PW'(w);
    assign w_o = PW'(w_ov);
    assign w_d = PW'(vds);

    always_comb begin
        w_id_num = '0;
        w_gm_num = '0;
        if (w_triode) begin
            // ov > V_DS guarantees 2*ov*V_DS >= V_DS^2, so no underflow.
            w_id_num = w_w * ((PW'(2) * w_o * w_d) - (w_d * w_d));
            w_gm_num = PW'(2) * w_w * w_d;
        end else begin
            w_id_num = w_w * w_o * w_o;
            w_gm_num = PW'(2) * w_w * w_o;
        end
    end

    assign value = sel_id ? VALW'(w_id_num / PW'(DIV_EVAL))
                          : VALW'(w_gm_num / PW'(DIV_EVAL));

endmodule
`default_nettype wire

// File: rtl/smc_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : smc_seq_core
//  Description : Sequential handshaked Super MOSFET Calculator. Latches one
//                transaction, evaluates one transistor per cycle through a
//                shared evaluator, sorts the six values, then emits a
//                weighted average of the largest or smallest three.
//  Ports       : clk, rst           - clock, async active-high reset
//                in_valid, mode     - transaction strobe and mode bits
//                W_n, V_GS_n, V_DS_n- six operand triplets (n = 0..5)
//                busy               - transaction in flight
//                out_valid, out_n   - one-cycle result strobe and result
//  Revision    : 1.0 - initial release
// ============================================================================
module smc_seq_core
    import smc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    mode,
    input  logic [VW-1:0] W_0,
    input  logic [VW-1:0] W_1,
    input  logic [VW-1:0] W_2,
    input  logic [VW-1:0] W_3,
    input  logic [VW-1:0] W_4,
    input  logic [VW-1:0] W_5,
    input  logic [VW-1:0] V_GS_0,
    input  logic [VW-1:0] V_GS_1,
    input  logic [VW-1:0] V_GS_2,
    input  logic [VW-1:0] V_GS_3,
    input  logic [VW-1:0] V_GS_4,
    input  logic [VW-1:0] V_GS_5,
    input  logic [VW-1:0] V_DS_0,
    input  logic [VW-1:0] V_DS_1,
    input  logic [VW-1:0] V_DS_2,
    input  logic [VW-1:0] V_DS_3,
    input  logic [VW-1:0] V_DS_4,
    input  logic [VW-1:0] V_DS_5,
    output logic          busy,
    output logic          out_valid,
    output logic [OW-1:0] out_n
);

    smc_state_t        r_state;
    smc_state_t        w_next;
    logic [IDXW-1:0]   r_idx;
    logic [1:0]        r_mode;
    logic [VW-1:0]     r_w   [N_TR];
    logic [VW-1:0]     r_vgs [N_TR];
    logic [VW-1:0]     r_vds [N_TR];
    logic [VALW-1:0]   r_val [N_TR];
    logic [VALW-1:0]   w_eval;
    logic [VALW-1:0]   w_s   [N_TR];
    logic [VALW-1:0]   w_tmp;
    logic [VALW-1:0]   w_n0, w_n1, w_n2;
    logic [SUMW-1:0]   w_sum_id;
    logic [SUMW-1:0]   w_sum_gm;
    logic [OW-1:0]     w_result;

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(N_TR - 1);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (r_idx == c_last_idx) w_next = SORT;
            SORT:    w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // ---------------- shared evaluator ----------------
    smc_eval_unit u_eval (
        .w      (r_w[r_idx]),
        .vgs    (r_vgs[r_idx]),
        .vds    (r_vds[r_idx]),
        .sel_id (r_mode[MODE_ID_BIT]),
        .value  (w_eval)
    );

    // ---------------- sort (descending bubble network) ----------------
    always_comb begin
        w_tmp = '0;
        for (int i = 0; i < N_TR; i++) w_s[i] = r_val[i];
        for (int i = 0; i < N_TR - 1; i++) begin
            for (int j = 0; j < N_TR - 1 - i; j++) begin
                if (w_s[j] < w_s[j+1]) begin
                    w_tmp    = w_s[j];
                    w_s[j]   = w_s[j+1];
                    w_s[j+1] = w_tmp;
                end
            end
        end
    end

    assign w_n0 = r_mode[MODE_MAX_BIT] ? w_s[0] : w_s[3];
    assign w_n1 = r_mode[MODE_MAX_BIT] ? w_s[1] : w_s[4];
    assign w_n2 = r_mode[MODE_MAX_BIT] ? w_s[2] : w_s[5];

    assign w_sum_id = SUMW'(WGT_N0) * SUMW'(w_n0)
                    + SUMW'(WGT_N1) * SUMW'(w_n1)
                    + SUMW'(WGT_N2) * SUMW'(w_n2);
    assign w_sum_gm = SUMW'(w_n0) + SUMW'(w_n1) + SUMW'(w_n2);

    assign w_result = r_mode[MODE_ID_BIT] ? OW'(w_sum_id / SUMW'(DIV_ID))
                                          : OW'(w_sum_gm / SUMW'(DIV_GM));

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_mode    <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
            for (int i = 0; i < N_TR; i++) begin
                r_w[i]   <= '0;
                r_vgs[i] <= '0;
                r_vds[i] <= '0;
                r_val[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_idx    <= '0;
                        r_mode   <= mode;
                        r_w[0]   <= W_0;    r_w[1]   <= W_1;    r_w[2]   <= W_2;
                        r_w[3]   <= W_3;    r_w[4]   <= W_4;    r_w[5]   <= W_5;
                        r_vgs[0] <= V_GS_0; r_vgs[1] <= V_GS_1; r_vgs[2] <= V_GS_2;
                        r_vgs[3] <= V_GS_3; r_vgs[4] <= V_GS_4; r_vgs[5] <= V_GS_5;
                        r_vds[0] <= V_DS_0; r_vds[1] <= V_DS_1; r_vds[2] <= V_DS_2;
                        r_vds[3] <= V_DS_3; r_vds[4] <= V_DS_4; r_vds[5] <= V_DS_5;
                    end
                end
                CALC: begin
                    r_val[r_idx] <= w_eval;
                    r_idx        <= (r_idx == c_last_idx) ? '0 : r_idx + IDXW'(1);
                end
                SORT: begin
                    out_n     <= w_result;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    out_n     <= '0;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smc_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smc_seq_core
//  Description : Self-checking bench for smc_seq_core with directed cases and
//                randomized back-to-back transactions against a reference
//                model computed from the transistor equations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smc_seq_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] mode;
    logic [2:0] tw  [6];
    logic [2:0] tg  [6];
    logic [2:0] td  [6];
    logic       busy;
    logic       out_valid;
    logic [9:0] out_n;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    smc_seq_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .W_0       (tw[0]), .W_1 (tw[1]), .W_2 (tw[2]),
        .W_3       (tw[3]), .W_4 (tw[4]), .W_5 (tw[5]),
        .V_GS_0    (tg[0]), .V_GS_1 (tg[1]), .V_GS_2 (tg[2]),
        .V_GS_3    (tg[3]), .V_GS_4 (tg[4]), .V_GS_5 (tg[5]),
        .V_DS_0    (td[0]), .V_DS_1 (td[1]), .V_DS_2 (td[2]),
        .V_DS_3    (td[3]), .V_DS_4 (td[4]), .V_DS_5 (td[5]),
        .busy      (busy),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    // Reference: evaluate each transistor from the equations, sort, pick, average.
    function automatic int model(input logic [1:0] m);
        int v[$];
        int n0, n1, n2;
        for (int i = 0; i < 6; i++) begin
            int w, g, d, ov, id, gm;
            w = int'(tw[i]); g = int'(tg[i]); d = int'(td[i]);
            ov = (g == 0) ? 0 : g - 1;
            if (ov > d) begin
                id = w * (2 * ov * d - d * d) / 3;
                gm = 2 * w * d / 3;
            end else begin
                id = w * ov * ov / 3;
                gm = 2 * w * ov / 3;
            end
            v.push_back(m[0] ? id : gm);
        end
        v.rsort();
        if (m[1]) begin n0 = v[0]; n1 = v[1]; n2 = v[2]; end
        else      begin n0 = v[3]; n1 = v[4]; n2 = v[5]; end
        return m[0] ? (3 * n0 + 4 * n1 + 5 * n2) / 12 : (n0 + n1 + n2) / 3;
    endfunction

    task automatic set_all(input int w, input int g, input int d);
        for (int i = 0; i < 6; i++) begin
            tw[i] = 3'(w); tg[i] = 3'(g); td[i] = 3'(d);
        end
    endtask

    task automatic set_ref_operands();
        tw[0] = 3'd7; tg[0] = 3'd7; td[0] = 3'd7;
        tw[1] = 3'd7; tg[1] = 3'd7; td[1] = 3'd1;
        tw[2] = 3'd1; tg[2] = 3'd1; td[2] = 3'd0;
        for (int i = 3; i < 6; i++) begin
            tw[i] = 3'd0; tg[i] = 3'($urandom_range(0, 7)); td[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 6; i++) begin
            tw[i] = 3'($urandom_range(0, 7));
            tg[i] = 3'($urandom_range(0, 7));
            td[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // Called at a negedge with operands set. Drives one strobe, then checks
    // every cycle up to and including the one where out_valid drops.
    // inject_at > 0 re-strobes in_valid with other data while busy.
    task automatic run_txn(input logic [1:0] m, input int exp, input int inject_at,
                           input string name);
        mode = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s accept_busy: busy=%b expected 1", name, busy);
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == inject_at) begin
                randomize_ops();
                mode = ~m;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            tests_run++;
            if (k < 7) begin
                if (out_valid !== 1'b0 || out_n !== 10'd0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s wait_c%0d: out_valid=%b out_n=%0d busy=%b expected 0/0/1",
                             name, k, out_valid, out_n, busy);
                end
            end else if (k == 7) begin
                if (out_valid !== 1'b1 || out_n !== 10'(exp)) begin
                    tests_failed++;
                    $display("FAIL %s result: out_valid=%b out_n=%0d expected 1/%0d",
                             name, out_valid, out_n, exp);
                end
            end else begin
                if (out_valid !== 1'b0 || out_n !== 10'd0 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s done: out_valid=%b out_n=%0d busy=%b expected 0/0/0",
                             name, out_valid, out_n, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        int exp;
        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; set_all(0, 0, 0);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_n !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b out_valid=%b out_n=%0d expected 0/0/0",
                     busy, out_valid, out_n);
        end
        rst = 1'b0;
        @(negedge clk);
        // Abort a transaction mid-CALC with an asynchronous reset.
        set_all(7, 7, 7);
        mode = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_n !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_async: busy=%b out_valid=%b out_n=%0d expected 0/0/0",
                     busy, out_valid, out_n);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || out_n !== 10'd0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_output: out_valid=%b out_n=%0d busy=%b expected 0/0/0",
                         out_valid, out_n, busy);
            end
        end
        set_all(1, 3, 3);
        exp = model(2'd1);
        run_txn(2'd1, 1, 0, "post_reset");
        tests_run++;
        if (exp !== 1) begin
            tests_failed++;
            $display("FAIL post_reset_model: model=%0d expected 1", exp);
        end
    endtask

    task automatic test_id_max();
        set_ref_operands();
        run_txn(2'd3, 29, 0, "id_max");
    endtask

    task automatic test_gm_max();
        set_ref_operands();
        run_txn(2'd2, 10, 0, "gm_max");
    endtask

    task automatic test_min();
        set_ref_operands();
        run_txn(2'd0, 0, 0, "gm_min");
        set_ref_operands();
        run_txn(2'd1, 0, 0, "id_min");
    endtask

    task automatic test_busy_reject();
        set_ref_operands();
        run_txn(2'd3, 29, 3, "busy_reject");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_reject_extra: out_valid=%b busy=%b expected 0/0",
                         out_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] m;
        int exp;
        for (int t = 0; t < 1000; t++) begin
            randomize_ops();
            m = 2'($urandom_range(0, 3));
            exp = model(m);
            run_txn(m, exp, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_id_max();
        test_gm_max();
        test_min();
        test_busy_reject();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smc_seq_core.md
Name: smc_seq_core

Overview:
Sequential, handshaked Super MOSFET Calculator core. It accepts one transaction of mode plus six (W, V_GS, V_DS) triplets and evaluates one transistor per cycle through a shared evaluation unit. It then selects three values and returns a 10-bit result with an out_valid strobe. The block is the responder behind the calculator stimulus/check bench and replaces the purely combinational calculator in the pipelined system.

Parameters:
N_TR, 6, transistors per transaction (fixed; the bench and sort network depend on it)
VW, 3, width of W, V_GS, V_DS
OW, 10, width of out_n

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock, asynchronous, active-high
in_valid  in  1  one-cycle strobe; mode and all triplets are valid this cycle
mode  in  2  bit0: 1=I_D, 0=gm; bit1: 1=largest three, 0=smallest three
W_0..W_5, V_GS_0..V_GS_5, V_DS_0..V_DS_5  in  3 each  transistor operands, unsigned
busy  out  1  high from the accept edge until out_valid is dropped
out_valid  out  1  one-cycle result strobe
out_n  out  10  result; 0 whenever out_valid=0

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, out_valid=0, out_n=0, counter=0, value regs cleared. Reset mid-transaction aborts it with no output.
- FSM: IDLE -> CALC -> SORT -> OUT -> IDLE.
- IDLE:
  - in_valid=1 latches mode and the 18 operands.
  - State goes to CALC, idx=0, busy=1.
- CALC, 6 cycles, idx 0..5:
  - Evaluate transistor idx and store the result in val[idx].
  - idx==5 -> SORT.
- Per-transistor value, with ov = V_GS-1 (V_GS=0 gives ov=0, clamped):
  - Triode when ov > V_DS: I_D = floor(W*(2*ov*V_DS - V_DS^2)/3), gm = floor(2*W*V_DS/3).
  - Otherwise saturation: I_D = floor(W*ov^2/3), gm = floor(2*W*ov/3).
  - Maximum I_D = 84 and maximum gm = 28, so val is 7 bits unsigned.
  - Intermediate products must be held at least 9 bits wide with no truncation before the divide.
- SORT, 1 cycle:
  - Combinational sort of val[0..5] into descending order s0>=...>=s5.
  - mode[1]=1 selects (n0,n1,n2)=(s0,s1,s2); mode[1]=0 selects (s3,s4,s5).
  - Result: I_D mode gives floor((3*n0+4*n1+5*n2)/12); gm mode gives floor((n0+n1+n2)/3).
  - The result is registered into out_n and out_valid=1 on the same edge, entering OUT.
- OUT, 1 cycle:
  - Next edge: out_valid=0, out_n=0, busy=0, back to IDLE.
- Latency: in_valid sampled at edge E; out_valid is high in the cycle after edge E+7 (7 cycles of processing).
- in_valid while busy=1 is ignored, with no queuing. in_valid in the cycle after out_valid drops is accepted.
- Ties in the sort have no effect, because only values are used.

Decomposition:
- Package smc_pkg:
  - Mode bit positions (MODE_ID_BIT=0, MODE_MAX_BIT=1).
  - VW, OW, and VALW=7.
  - FSM state enum {IDLE, CALC, SORT, OUT}.
  - Weights 3/4/5 and divisors 3/12.
- Sub-module smc_eval_unit: combinational, (W, V_GS, V_DS, sel_id) -> 7-bit value; instantiated once and time-shared by idx.

Test Plan:
- Reset: assert rst asynchronously mid-CALC -> out_valid=0, out_n=0, busy=0 immediately. Then one transaction with all six at W=1, V_GS=3, V_DS=3, mode=1 -> out_n=1.
- I_D, largest three (mode=3):
  - Inputs: T0=(7,7,7) gives 84; T1=(7,7,1) gives 25; T2=(1,1,0) gives 0; T3..T5 have W=0.
  - Required: out_n=(252+100+0)/12=29, with out_valid high 7 cycles after acceptance.
- gm, largest three: same operands with mode=2 -> values 28, 4, 0, ... -> out_n=10.
- Smallest three: same operands with mode=0 -> out_n=0; with mode=1 -> out_n=0.
- Busy rejection: second in_valid 3 cycles after the first, with different data -> ignored. Exactly one out_valid, carrying the first transaction's result.
- Back-to-back: in_valid in the first cycle after out_valid drops -> accepted. 1000 random transactions must match the golden model, with out_n=0 outside out_valid.
